// File: rtl/hc04_selftest_seq.sv
// Self-test sequencer for a bank of WIDTH inverters: sweeps every input vector, checks Y == ~A.
// Optional macro HC04_SELFTEST_STOP_ON_FAIL_EN ends the sweep at the first failing vector.
module hc04_selftest_seq #(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  output logic [WIDTH-1:0] DUT_A,
  input  logic [WIDTH-1:0] DUT_Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [WIDTH-1:0] FAIL_MASK,
  output logic [1:0]       STATE_DBG
);
  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] A_LAST   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_d, mask_d, mism;
  logic [ERR_W-1:0] err_d;
  logic             busy_d, done_d, pass_d, last_vec;

  // START and ABORT are level strobes with no ready: START is taken on any
  // IDLE edge it is high, ABORT on any non-IDLE edge it is high.
  assign mism      = DUT_Y ^ ~DUT_A;
  assign STATE_DBG = state_q;

`ifdef HC04_SELFTEST_STOP_ON_FAIL_EN
  assign last_vec = (DUT_A == A_LAST) || (|mism);
`else
  assign last_vec = (DUT_A == A_LAST);
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      DUT_A     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_MASK <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      DUT_A     <= a_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      PASS      <= pass_d;
      ERR_CNT   <= err_d;
      FAIL_MASK <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = DUT_A;
    busy_d  = BUSY;
    done_d  = DONE;
    pass_d  = PASS;
    err_d   = ERR_CNT;
    mask_d  = FAIL_MASK;
    if (state_q != S_IDLE && ABORT) begin
      // Partial ERR_CNT/FAIL_MASK are kept for inspection after an abort.
      state_d = S_IDLE;
      a_d     = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
            a_d     = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            mask_d  = '0;
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (|mism) begin
            err_d  = (ERR_CNT == ERR_MAX) ? ERR_CNT : ERR_CNT + ERR_W'(1);
            mask_d = FAIL_MASK | mism;
          end
          if (last_vec) begin
            state_d = S_FIN;
          end else begin
            a_d     = DUT_A + WIDTH'(1);
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (ERR_CNT == '0) && (FAIL_MASK == '0);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule
